// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian words and writes them to IMEM.
// Optional trailer checksum verification is enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] n_words,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] cksum
);

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 2;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, FIN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] word_q, word_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [NW-1:0] n_q, n_d;
  logic [DW-1:0] cksum_q, cksum_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          accept_c;
  logic          start_ok_c;
  logic          last_word_c;
  logic [DW-1:0] word_next_c;

  assign accept_c    = in_valid && in_ready_q;
  // Shifting in from the top leaves the first byte in bits [7:0] after four transfers.
  assign word_next_c = {in_data, word_q[DW-1:BW]};
  assign start_ok_c  = (n_words != '0) && ({16'd0, n_words} <= DEPTH);
  assign last_word_c = (idx_q == (n_q - NW'(1)));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      cksum_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      cksum_q     <= cksum_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    idx_d       = idx_q;
    n_d         = n_q;
    cksum_d     = cksum_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok_c) begin
            err_d      = 1'b0;
            idx_d      = '0;
            byte_cnt_d = '0;
            cksum_d    = '0;
            word_d     = '0;
            n_d        = n_words;
            state_d    = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (accept_c) begin
          word_d     = word_next_c;
          byte_cnt_d = byte_cnt_q + CW'(1);
          if (byte_cnt_q == CW'(3)) begin
            state_d     = WRITE;
            mem_addr_d  = DW'({idx_q, 2'b00});
            mem_wdata_d = word_next_c;
          end
        end
      end
      WRITE: begin
        idx_d = idx_q + NW'(1);
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_d = cksum_q + word_q;
        state_d = last_word_c ? CHK : RECV;
`else
        state_d = last_word_c ? FIN : RECV;
`endif
      end
      CHK: begin
`ifdef IMEM_LOADER_CKSUM_EN
        if (accept_c) begin
          word_d     = word_next_c;
          byte_cnt_d = byte_cnt_q + CW'(1);
          if (byte_cnt_q == CW'(3)) begin
            if (word_next_c == cksum_q) begin
              state_d = FIN;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
`else
        state_d = IDLE;
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_we_d   = (state_d == WRITE);
    in_ready_d = (state_d == RECV) || (state_d == CHK);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cksum     = cksum_q;

endmodule
